xbar_conflict_sched: RTL

//  Upstream stage of the shift crossbar (xbar). Accepts one batch of SIZE lane requests (data +

---
 rtl/xbar_conflict_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/xbar_conflict_sched.sv
// Conflict scheduler in front of the shift crossbar: splits one batch of lane requests into
// passes that each write any destination lane at most once.
module xbar_conflict_sched #(
    parameter int unsigned SIZE   = 32,
    parameter int unsigned DWIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIZE-1:0]              in_mask,
    input  logic [SIZE*DWIDTH-1:0]       in_data,
    input  logic [SIZE*$clog2(SIZE)-1:0] in_dst,
    input  logic                         stall,
    output logic                         xbar_en,
    output logic [SIZE*DWIDTH-1:0]       xbar_din,
    output logic [SIZE*$clog2(SIZE)-1:0] xbar_shift,
    output logic [SIZE-1:0]              xbar_dst_vld,
    output logic                         xbar_last,
    output logic [$clog2(SIZE):0]        pass_cnt
);

    localparam int unsigned LW = $clog2(SIZE);
    localparam int unsigned CW = LW + 1;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                       state_q, state_d;
    logic [SIZE-1:0]              pending_q, pending_d;
    logic [CW-1:0]                pass_cnt_q, pass_cnt_d;
    logic [SIZE-1:0][DWIDTH-1:0]  data_q;
    logic [SIZE-1:0][LW-1:0]      dst_q;
    logic [SIZE-1:0]              grant;
    logic                         capture;

    // Lowest pending index claims each destination; higher lanes sharing it wait a pass.
    always_comb begin
        grant = '0;
        for (int i = 0; i < SIZE; i++) begin
            grant[i] = pending_q[i] && (state_q == StIssue);
            for (int j = 0; j < SIZE; j++) begin
                if (j < i && pending_q[j] && dst_q[j] == dst_q[i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        xbar_din     = '0;
        xbar_shift   = '0;
        xbar_dst_vld = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (grant[i]) begin
                xbar_din[i*DWIDTH +: DWIDTH] = data_q[i];
                xbar_shift[i*LW +: LW]       = dst_q[i] - LW'(i);
                xbar_dst_vld[dst_q[i]]       = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pass_cnt_d = pass_cnt_q;
        in_ready   = 1'b0;
        xbar_en    = 1'b0;
        xbar_last  = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    pending_d  = in_mask;
                    pass_cnt_d = '0;
                    if (|in_mask) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                xbar_en   = !stall;
                xbar_last = ~|(pending_q & ~grant);
                if (xbar_en) begin
                    pending_d = pending_q & ~grant;
                    if (xbar_last) begin
                        state_d    = StIdle;
                        pass_cnt_d = '0;
                    end else begin
                        pass_cnt_d = pass_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    // Payload needs no reset: it is only observed through grant, which pending gates.
    always_ff @(posedge clk) begin
        if (capture) begin
            data_q <= in_data;
            dst_q  <= in_dst;
        end
    end

    assign pass_cnt = pass_cnt_q;

endmodule
